hex_display_ctrl: RTL
=====================

Name: hex_display_ctrl

Overview:
- CPU-side output peripheral that drives the eight active-low seven-segment displays HEX7..HEX0 from a 32-bit value the processor writes to its display I/O register.
- Two render modes:
  - Hex mode: one nibble per display, latency 1 cycle.
  - Decimal mode: sequential double-dabble binary-to-BCD converter, 32 shift cycles, with leading-zero blanking and overflow indication.
- Sits between the CPU I/O-write path and the board-level HEX pins.

Parameters:
- CONV_BITS, 32, width of the value converted in decimal mode; also the number of shift cycles.
- NUM_DIGITS, 8, number of displays driven.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  one-cycle write strobe from the CPU I/O register write.
- wr_data  input  32  value to display; sampled when wr_en=1.
- wr_dec  input  1  mode for this write: 1 = decimal, 0 = hex; sampled with wr_data.
- busy  output  1  high while a decimal conversion is in flight.
- pend  output  1  high while a one-deep pending write is held.
- HEX0..HEX7  output  7 each  segments {g,f,e,d,c,b,a}, active-low; HEX0 is the least-significant digit.

Behaviour:
- Reset (async, any state): FSM -> IDLE; busy=0; pend=0; all HEX = 7'b1111111 (blank); BCD shift register and pending register cleared. Reset mid-conversion aborts the conversion and keeps the displays blank.
- Segment codes 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - Dash = 0111111.
  - Blank = 1111111.
- HEX outputs are registered and change only at an UPDATE edge (or reset). All other edges hold them.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE, write sampled at edge T (wr_en=1, or pend=1 with no new write):
  - wr_dec=0: the eight nibbles are written to HEX at edge T+1. No blanking. busy stays 0.
  - wr_dec=1: latch the value and clear the 32-bit BCD register; busy=1 from edge T; FSM -> SHIFT; shift counter = 0.
- SHIFT, one iteration per edge T+1..T+32:
  - Each BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - The counter increments; after the 32nd shift, FSM -> UPDATE.
- UPDATE, edge T+33:
  - The 8 BCD digits are written to HEX; busy=0; FSM -> IDLE.
  - Leading-zero blanking: every digit above the most-significant nonzero digit is blank. HEX0 always shows its digit, so value 0 shows "0".
- Overflow: if the latched value >= 100_000_000, the UPDATE edge writes dash to all eight displays instead of digits. Detection compares the latched binary value, not the BCD carry.
- Writes while busy (SHIFT or UPDATE):
  - Data and mode go into the pending register; pend=1. Last write wins if several arrive.
  - The conversion in progress is not disturbed.
- Pending drain: on the edge after UPDATE (IDLE), the pending entry is consumed exactly as a fresh IDLE write and pend clears at that edge.
  - A new wr_en on that same edge overwrites the pending data, and the new data is the one started.
- wr_en in IDLE with pend=0 is never dropped. A hex write in IDLE does not assert busy.
- Arithmetic: BCD register is 4*NUM_DIGITS bits. Bits shifted past the top digit are discarded; overflow detection covers this case.

Test Plan:
- Reset, then decimal write 12345678 -> busy high for 33 cycles; at T+33 HEX7..HEX0 show 1,2,3,4,5,6,7,8; busy=0.
- Decimal write 42 -> HEX1='4' (0011001), HEX0='2' (0100100), HEX7..HEX2 blank. Decimal write 0 -> HEX0=1000000, others blank.
- Decimal write 100000000 and 32'hFFFFFFFF -> all HEX = 0111111 at T+33. Decimal write 99999999 -> all eight show '9'.
- Hex write 32'hDEADBEEF -> at T+1 HEX7..HEX0 = d,E,A,d,b,E,E,F; busy never asserts.
- Decimal write 7, then at T+5 write 55 and at T+10 hex write 32'h0000ABCD:
  - pend=1 from T+5.
  - T+33 shows "7".
  - Next cycle starts the hex write; HEX = 0,0,0,0,A,b,C,d; 55 is never shown.
- Decimal write 999, assert rst at T+15 for 1 cycle -> busy=0, pend=0, all blank immediately. A subsequent decimal write of 5 completes normally with HEX0='5'.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: drives eight active-low 7-segment displays from a CPU-written value,
// rendered either as raw hex nibbles or as blanked decimal via a sequential double-dabble.
module hex_display_ctrl #(
    parameter int CONV_BITS  = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CONV_BITS-1:0] wr_data,
    input  logic                 wr_dec,
    output logic                 busy,
    output logic                 pend,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5,
    output logic [6:0]           HEX6,
    output logic [6:0]           HEX7
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(CONV_BITS);
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                       state_q, state_d;
    logic [CONV_BITS-1:0]         bin_q, bin_d, pdata_q, pdata_d;
    logic [BW-1:0]                bcd_q, bcd_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         dec_q, dec_d, ovf_q, ovf_d;
    logic                         pend_q, pend_d, pdec_q, pdec_d;
    logic [NUM_DIGITS-1:0][6:0]   seg_q, seg_d;
    logic                         start, s_dec, nz;
    logic [CONV_BITS-1:0]         s_data;
    logic [BW-1:0]                adj;
    logic [NUM_DIGITS-1:0][6:0]   dec_seg, hex_seg;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        pdata_d = pdata_q;
        pdec_d  = pdec_q;
        seg_d   = seg_q;
        start   = state_q == IDLE && (wr_en || pend_q);
        s_data  = wr_en ? wr_data : pdata_q;
        s_dec   = wr_en ? wr_dec : pdec_q;
        // A live write always wins over the held one; the held entry is consumed by any start.
        if (wr_en && state_q != IDLE) begin
            pend_d  = 1'b1;
            pdata_d = wr_data;
            pdec_d  = wr_dec;
        end else if (start) begin
            pend_d = 1'b0;
        end
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
        nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz         = nz | (bcd_q[4*i+:4] != 4'd0);
            dec_seg[i] = ovf_q ? DASH : (nz || i == 0) ? seg7(bcd_q[4*i+:4]) : BLANK;
            hex_seg[i] = seg7(bin_q[4*i+:4]);
        end
        case (state_q)
            IDLE: if (start) begin
                bin_d   = s_data;
                bcd_d   = '0;
                cnt_d   = '0;
                dec_d   = s_dec;
                ovf_d   = 64'(s_data) >= LIMIT;
                state_d = s_dec ? SHIFT : UPDATE;
            end
            SHIFT: begin
                bcd_d = {adj[BW-2:0], bin_q[CONV_BITS-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(CONV_BITS - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                seg_d   = dec_q ? dec_seg : hex_seg;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            pdata_q <= '0;
            pdec_q  <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            pdec_q  <= pdec_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = state_q != IDLE && dec_q;
    assign pend = pend_q;
    assign {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = seg_q;
endmodule
